pc_fetch: RTL

- Fetch-side counterpart of the next-PC logic: owns the architectural PC register and issues word-address requests to instruction memory.
- Delivers fetched instructions into the IF/ID register, and supplies cur_pc (word address of the ID instruction + 1) back to the next-PC logic.
- Accepts a redirect with a target word address from the decode stage.
- Sits between instruction memory and the decode stage of the 5-stage pipeline.

---
 rtl/pc_fetch.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/pc_fetch.sv
// Fetch stage: owns the architectural PC, issues one-at-a-time word fetches, fills IF/ID.
// Optional PC_FETCH_PERF_EN adds perf_fetched/perf_stall counter outputs.
module pc_fetch #(
    parameter logic [29:0] RESET_PC = 30'd0,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [29:0] next_pc,
    input  logic        redirect,
    input  logic        stall,
    output logic        imem_req,
    output logic [29:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [29:0] id_pc,
    output logic [29:0] cur_pc
`ifdef PC_FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t      state_r, state_nxt_s;
    logic [29:0] fetch_pc_r, fetch_pc_nxt_s;
    logic [29:0] req_pc_r, req_pc_nxt_s;
    logic        kill_r, kill_nxt_s;
    logic        imem_req_r;
    logic        id_valid_r, id_valid_nxt_s;
    logic [31:0] id_inst_r, id_inst_nxt_s;
    logic [29:0] id_pc_r, id_pc_nxt_s;
    logic [29:0] cur_pc_r;
    logic        skid_valid_r, skid_valid_nxt_s;
    logic [31:0] skid_inst_r, skid_inst_nxt_s;
    logic [29:0] skid_pc_r, skid_pc_nxt_s;
    logic        accept_s;
    logic        rsp_live_s;
    logic        id_free_s;

    assign accept_s   = (state_r == ST_REQ) && imem_ready;
    assign rsp_live_s = imem_rvalid && (state_r == ST_WAIT) && !kill_r;
    assign id_free_s  = !stall || !id_valid_r;

    // Next-state, PC, kill, IF/ID and skid-buffer update
    always_comb begin
        state_nxt_s      = state_r;
        fetch_pc_nxt_s   = fetch_pc_r;
        req_pc_nxt_s     = req_pc_r;
        kill_nxt_s       = kill_r;
        id_valid_nxt_s   = id_valid_r;
        id_inst_nxt_s    = id_inst_r;
        id_pc_nxt_s      = id_pc_r;
        skid_valid_nxt_s = skid_valid_r;
        skid_inst_nxt_s  = skid_inst_r;
        skid_pc_nxt_s    = skid_pc_r;

        // A response arriving while kill is set belongs to a squashed fetch.
        if (imem_rvalid && kill_r) begin
            kill_nxt_s = 1'b0;
        end else begin
            kill_nxt_s = kill_r;
        end

        if (accept_s) begin
            req_pc_nxt_s = fetch_pc_r;
        end else begin
            req_pc_nxt_s = req_pc_r;
        end

        if (redirect) begin
            fetch_pc_nxt_s   = next_pc;
            id_valid_nxt_s   = 1'b0;
            skid_valid_nxt_s = 1'b0;
            state_nxt_s      = ST_REQ;
            if (((state_r == ST_WAIT) && !imem_rvalid) || accept_s) begin
                kill_nxt_s = 1'b1;
            end else begin
                kill_nxt_s = kill_nxt_s;
            end
        end else begin
            if (id_free_s) begin
                if (skid_valid_r) begin
                    id_valid_nxt_s = 1'b1;
                    id_inst_nxt_s  = skid_inst_r;
                    id_pc_nxt_s    = skid_pc_r;
                    if (rsp_live_s) begin
                        skid_inst_nxt_s = imem_rdata;
                        skid_pc_nxt_s   = req_pc_r;
                    end else begin
                        skid_valid_nxt_s = 1'b0;
                    end
                end else if (rsp_live_s) begin
                    id_valid_nxt_s = 1'b1;
                    id_inst_nxt_s  = imem_rdata;
                    id_pc_nxt_s    = req_pc_r;
                end else begin
                    id_valid_nxt_s = 1'b0;
                end
            end else begin
                if (rsp_live_s) begin
                    skid_valid_nxt_s = 1'b1;
                    skid_inst_nxt_s  = imem_rdata;
                    skid_pc_nxt_s    = req_pc_r;
                end else begin
                    skid_valid_nxt_s = skid_valid_r;
                end
            end

            // A killed response leaves us in WAIT: the redirected fetch is still outstanding.
            case (state_r)
                ST_IDLE: begin
                    if (!skid_valid_nxt_s) begin
                        state_nxt_s = ST_REQ;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (imem_ready) begin
                        state_nxt_s    = ST_WAIT;
                        fetch_pc_nxt_s = fetch_pc_r + 30'd1;
                    end else begin
                        state_nxt_s = ST_REQ;
                    end
                end
                ST_WAIT: begin
                    if (rsp_live_s) begin
                        state_nxt_s = skid_valid_nxt_s ? ST_IDLE : ST_REQ;
                    end else begin
                        state_nxt_s = ST_WAIT;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end

        if (!id_valid_nxt_s) begin
            id_inst_nxt_s = NOP_INST;
        end else begin
            id_inst_nxt_s = id_inst_nxt_s;
        end
    end

    // Pipeline state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            fetch_pc_r   <= RESET_PC;
            req_pc_r     <= RESET_PC;
            kill_r       <= 1'b0;
            imem_req_r   <= 1'b0;
            id_valid_r   <= 1'b0;
            id_inst_r    <= NOP_INST;
            id_pc_r      <= RESET_PC;
            cur_pc_r     <= RESET_PC + 30'd1;
            skid_valid_r <= 1'b0;
            skid_inst_r  <= NOP_INST;
            skid_pc_r    <= RESET_PC;
        end else begin
            state_r      <= state_nxt_s;
            fetch_pc_r   <= fetch_pc_nxt_s;
            req_pc_r     <= req_pc_nxt_s;
            kill_r       <= kill_nxt_s;
            imem_req_r   <= (state_nxt_s == ST_REQ);
            id_valid_r   <= id_valid_nxt_s;
            id_inst_r    <= id_inst_nxt_s;
            id_pc_r      <= id_pc_nxt_s;
            cur_pc_r     <= id_pc_nxt_s + 30'd1;
            skid_valid_r <= skid_valid_nxt_s;
            skid_inst_r  <= skid_inst_nxt_s;
            skid_pc_r    <= skid_pc_nxt_s;
        end
    end

    assign imem_req  = imem_req_r;
    assign imem_addr = fetch_pc_r;
    assign id_valid  = id_valid_r;
    assign id_inst   = id_inst_r;
    assign id_pc     = id_pc_r;
    assign cur_pc    = cur_pc_r;

`ifdef PC_FETCH_PERF_EN
    logic [31:0] perf_fetched_r;
    logic [31:0] perf_stall_r;

    // Event counters; redirects do not clear them
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched_r <= 32'd0;
            perf_stall_r   <= 32'd0;
        end else begin
            if (rsp_live_s && !redirect) begin
                perf_fetched_r <= perf_fetched_r + 32'd1;
            end else begin
                perf_fetched_r <= perf_fetched_r;
            end
            if (stall && id_valid_r) begin
                perf_stall_r <= perf_stall_r + 32'd1;
            end else begin
                perf_stall_r <= perf_stall_r;
            end
        end
    end

    assign perf_fetched = perf_fetched_r;
    assign perf_stall   = perf_stall_r;
`endif

endmodule
